// File: rtl/hazard_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_unit_if
//  Bundle between the pipeline datapath and hazard_unit.
//  Pipeline -> hazard unit : ihit, dhit, exm_dREN, exm_dWEN, exm_redirect,
//                            idex_MemRead, idex_rt_out, ifid_rs, ifid_rt
//  Hazard unit -> pipeline : pc_en, ifid_en, idex_en, exm_en, mwb_en,
//                            ifid_flush, idex_flush, exm_flush, redirect_take
//                            (+ stall_cnt, flush_cnt when HAZARD_STATS_EN)
//  Parameters: REG_W register-index width, CNT_W statistics counter width.
//  Optional feature macro: HAZARD_STATS_EN (adds the two counters).
//  Modports: master = pipeline side, slave = hazard_unit side.
// ---------------------------------------------------------------------------
interface hazard_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  typedef logic [REG_W-1:0] regIdx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Pipeline status
  logic    ihit;
  logic    dhit;
  logic    exm_dREN;
  logic    exm_dWEN;
  logic    exm_redirect;
  logic    idex_MemRead;
  regIdx_t idex_rt_out;
  regIdx_t ifid_rs;
  regIdx_t ifid_rt;

  // Pipeline control
  logic    pc_en;
  logic    ifid_en;
  logic    idex_en;
  logic    exm_en;
  logic    mwb_en;
  logic    ifid_flush;
  logic    idex_flush;
  logic    exm_flush;
  logic    redirect_take;

`ifdef HAZARD_STATS_EN
  cnt_t    stall_cnt;
  cnt_t    flush_cnt;
`endif

  modport master (
    output ihit, dhit, exm_dREN, exm_dWEN, exm_redirect,
           idex_MemRead, idex_rt_out, ifid_rs, ifid_rt,
    input  pc_en, ifid_en, idex_en, exm_en, mwb_en,
           ifid_flush, idex_flush, exm_flush, redirect_take
`ifdef HAZARD_STATS_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  ihit, dhit, exm_dREN, exm_dWEN, exm_redirect,
           idex_MemRead, idex_rt_out, ifid_rs, ifid_rt,
    output pc_en, ifid_en, idex_en, exm_en, mwb_en,
           ifid_flush, idex_flush, exm_flush, redirect_take
`ifdef HAZARD_STATS_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//  Pipeline control for the hazards forwarding cannot hide: load-use,
//  data-memory wait, instruction-fetch miss and a taken branch/jump resolved
//  in EX/MEM. Produces PC / latch enables, latch flushes and the PC-mux
//  redirect select. Control outputs are combinational from state + inputs.
//
//  Ports:
//    CLK  in  system clock, rising edge
//    RST  in  asynchronous active-high reset
//    hz   hazard_unit_if.slave (status in, control out; see interface file)
//
//  Optional feature: define HAZARD_STATS_EN to add saturating stall_cnt and
//  flush_cnt counters (CNT_W bits, from the interface) on the interface.
// ---------------------------------------------------------------------------
module hazard_unit (
  input  logic           CLK,
  input  logic           RST,
  hazard_unit_if.slave   hz
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    REDIR_PEND = 2'd2
  } state_t;

  state_t stateReg;
  state_t stateNext;

  logic memWait;
  logic loadUse;

  logic pcEn;
  logic ifidEn;
  logic idexEn;
  logic exmEn;
  logic mwbEn;
  logic ifidFlush;
  logic idexFlush;
  logic exmFlush;
  logic redirectTake;

  assign memWait = (hz.exm_dREN | hz.exm_dWEN) & ~hz.dhit;

  // A load writing $0 never creates a real dependency.
  assign loadUse = hz.idex_MemRead
                 & (hz.idex_rt_out != '0)
                 & ((hz.idex_rt_out == hz.ifid_rs) | (hz.idex_rt_out == hz.ifid_rt));

  // Control decode. Priority: memWait > redirect > loadUse > ~ihit > normal.
  always_comb begin
    pcEn         = 1'b1;
    ifidEn       = 1'b1;
    idexEn       = 1'b1;
    exmEn        = 1'b1;
    mwbEn        = 1'b1;
    ifidFlush    = 1'b0;
    idexFlush    = 1'b0;
    exmFlush     = 1'b0;
    redirectTake = 1'b0;
    stateNext    = RUN;

    if (RST) begin
      // Reset asserts immediately on the outputs, not just at the next edge.
      pcEn      = 1'b0;
      ifidEn    = 1'b0;
      idexEn    = 1'b0;
      exmEn     = 1'b0;
      mwbEn     = 1'b0;
      ifidFlush = 1'b1;
      idexFlush = 1'b1;
      exmFlush  = 1'b1;
      stateNext = RUN;
    end else if ((stateReg == REDIR_PEND) && !hz.dhit) begin
      // Memory still busy with a redirect queued: keep everything frozen.
      pcEn      = 1'b0;
      ifidEn    = 1'b0;
      idexEn    = 1'b0;
      exmEn     = 1'b0;
      mwbEn     = 1'b0;
      stateNext = REDIR_PEND;
    end else if ((stateReg == REDIR_PEND) || (!memWait && hz.exm_redirect)) begin
      // Redirect: every latch advances, the three younger stages take a
      // bubble, and the PC loads the target even if the fetch has not hit.
      ifidFlush    = 1'b1;
      idexFlush    = 1'b1;
      exmFlush     = 1'b1;
      redirectTake = 1'b1;
      stateNext    = RUN;
    end else if (memWait) begin
      // Freeze everything up to and including EX/MEM. MEM/WB only accepts
      // on dhit, which memWait excludes, so it is held as well.
      pcEn      = 1'b0;
      ifidEn    = 1'b0;
      idexEn    = 1'b0;
      exmEn     = 1'b0;
      mwbEn     = 1'b0;
      // A redirect seen during the wait is remembered and applied on dhit.
      stateNext = hz.exm_redirect ? REDIR_PEND : MEM_WAIT;
    end else if (loadUse) begin
      // Hold PC and IF/ID one cycle; ID/EX takes a bubble. The bubble clears
      // idex_MemRead so the stall cannot re-trigger on the same pair.
      pcEn      = 1'b0;
      ifidEn    = 1'b0;
      idexFlush = 1'b1;
      stateNext = RUN;
    end else if (!hz.ihit) begin
      // Fetch miss: hold PC, push a bubble into IF/ID, let the rest drain.
      pcEn      = 1'b0;
      ifidFlush = 1'b1;
      stateNext = RUN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stateReg <= RUN;
    end else begin
      stateReg <= stateNext;
    end
  end

  assign hz.pc_en         = pcEn;
  assign hz.ifid_en       = ifidEn;
  assign hz.idex_en       = idexEn;
  assign hz.exm_en        = exmEn;
  assign hz.mwb_en        = mwbEn;
  assign hz.ifid_flush    = ifidFlush;
  assign hz.idex_flush    = idexFlush;
  assign hz.exm_flush     = exmFlush;
  assign hz.redirect_take = redirectTake;

`ifdef HAZARD_STATS_EN
  // Saturating event counters: stall = PC held, flush = redirect applied.
  logic [$bits(hz.stall_cnt)-1:0] stallCntReg;
  logic [$bits(hz.flush_cnt)-1:0] flushCntReg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stallCntReg <= '0;
      flushCntReg <= '0;
    end else begin
      if (!pcEn && (stallCntReg != '1)) begin
        stallCntReg <= stallCntReg + 1'b1;
      end
      if (redirectTake && (flushCntReg != '1)) begin
        flushCntReg <= flushCntReg + 1'b1;
      end
    end
  end

  assign hz.stall_cnt = stallCntReg;
  assign hz.flush_cnt = flushCntReg;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
//  Directed vectors for hazard_unit. Each vector is applied just after a
//  rising edge, outputs are checked on the following falling edge.
//  Expected control word layout (9 bits, MSB first):
//    pc_en ifid_en idex_en exm_en mwb_en ifid_flush idex_flush exm_flush redirect_take
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_unit;

  logic CLK;
  logic RST;

`ifdef HAZARD_STATS_EN
  hazard_unit_if #(.REG_W(5), .CNT_W(4)) hzIf ();
`else
  hazard_unit_if #(.REG_W(5), .CNT_W(32)) hzIf ();
`endif

  hazard_unit dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (hzIf.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [8:0] RESET_W = 9'b00000_111_0;
  localparam logic [8:0] NORMAL  = 9'b11111_000_0;
  localparam logic [8:0] LOADUSE = 9'b00111_010_0;
  localparam logic [8:0] NOIHIT  = 9'b01111_100_0;
  localparam logic [8:0] FREEZE  = 9'b00000_000_0;
  localparam logic [8:0] REDIR   = 9'b11111_111_1;

  int testsRun    = 0;
  int testsFailed = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [8:0] ctrlWord();
    return {hzIf.pc_en, hzIf.ifid_en, hzIf.idex_en, hzIf.exm_en, hzIf.mwb_en,
            hzIf.ifid_flush, hzIf.idex_flush, hzIf.exm_flush, hzIf.redirect_take};
  endfunction

  // Drive one cycle of stimulus, check the control word mid-cycle.
  task automatic applyVec(input string tag, input logic rst,
                          input logic ihit, input logic dhit,
                          input logic dren, input logic dwen, input logic redir,
                          input logic memRead, input logic [4:0] ldRt,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic [8:0] exp);
    RST               = rst;
    hzIf.ihit         = ihit;
    hzIf.dhit         = dhit;
    hzIf.exm_dREN     = dren;
    hzIf.exm_dWEN     = dwen;
    hzIf.exm_redirect = redir;
    hzIf.idex_MemRead = memRead;
    hzIf.idex_rt_out  = ldRt;
    hzIf.ifid_rs      = rs;
    hzIf.ifid_rt      = rt;
    @(negedge CLK);
    checkVal(tag, {23'd0, ctrlWord()}, {23'd0, exp});
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    #1;
    // 1: reset holds everything, then normal flow
    for (int i = 0; i < 3; i++) applyVec("reset", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, RESET_W);
    applyVec("normal", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, NORMAL);

    // 2: load-use on rs, then on rt, each a single stall cycle
    applyVec("loaduse_rs", 0, 1, 0, 0, 0, 0, 1, 8, 8, 3, LOADUSE);
    applyVec("after_lu_rs", 0, 1, 0, 0, 0, 0, 0, 0, 8, 3, NORMAL);
    applyVec("loaduse_rt", 0, 1, 0, 0, 0, 0, 1, 12, 4, 12, LOADUSE);
    applyVec("no_match", 0, 1, 0, 0, 0, 0, 1, 12, 4, 5, NORMAL);

    // 3: load to $0 never stalls
    applyVec("rt_zero", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, NORMAL);

    // 4: d-mem wait with a redirect held until dhit
    for (int i = 0; i < 4; i++) applyVec("redir_wait", 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, FREEZE);
    applyVec("redir_apply", 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, REDIR);
    applyVec("after_redir", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, NORMAL);

    // plain store wait, no redirect
    applyVec("st_wait0", 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, FREEZE);
    applyVec("st_wait1", 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, FREEZE);
    applyVec("st_done", 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, NORMAL);

    // 5: simultaneous events
    applyVec("noihit_lu", 0, 0, 0, 0, 0, 0, 1, 8, 8, 0, LOADUSE);
    applyVec("noihit_redir", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, REDIR);
    applyVec("noihit", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NOIHIT);
    applyVec("lu_redir", 0, 1, 0, 0, 0, 1, 1, 9, 9, 0, REDIR);
    applyVec("memwait_redir_lu", 0, 0, 0, 1, 0, 1, 1, 9, 9, 0, FREEZE);
    applyVec("pend_exit", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, REDIR);

    // reset in the middle of a pending redirect drops it
    applyVec("pend_a", 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, FREEZE);
    applyVec("pend_b", 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, FREEZE);
    applyVec("rst_mid", 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, RESET_W);
    applyVec("pend_dropped", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, NORMAL);

`ifdef HAZARD_STATS_EN
    // 6: saturating counters
    applyVec("stats_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, RESET_W);
    checkVal("stall_cnt_rst", {28'd0, hzIf.stall_cnt}, 32'd0);
    checkVal("flush_cnt_rst", {28'd0, hzIf.flush_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) applyVec("stats_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NOIHIT);
    checkVal("stall_cnt_5", {28'd0, hzIf.stall_cnt}, 32'd5);
    for (int i = 0; i < 15; i++) applyVec("stats_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NOIHIT);
    checkVal("stall_cnt_sat", {28'd0, hzIf.stall_cnt}, 32'd15);
    applyVec("stats_redir", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, REDIR);
    applyVec("stats_redir", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, REDIR);
    checkVal("flush_cnt_2", {28'd0, hzIf.flush_cnt}, 32'd2);
    checkVal("stall_cnt_hold", {28'd0, hzIf.stall_cnt}, 32'd15);
    applyVec("stats_rst2", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, RESET_W);
    checkVal("stall_cnt_clr", {28'd0, hzIf.stall_cnt}, 32'd0);
    checkVal("flush_cnt_clr", {28'd0, hzIf.flush_cnt}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
